// File: rtl/ibex_cheri_tag_ctrl_if.sv
// LSU-side tag access bus: req/gnt request phase plus a one-cycle-latency response.
interface ibex_cheri_tag_ctrl_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic        cap;
    logic [31:0] addr;
    logic        wdata_tag;
    logic        rvalid;
    logic        rdata_tag;
    logic        err;

    modport master (
        output req, we, cap, addr, wdata_tag,
        input  gnt, rvalid, rdata_tag, err
    );

    modport slave (
        input  req, we, cap, addr, wdata_tag,
        output gnt, rvalid, rdata_tag, err
    );
endinterface

// File: rtl/ibex_cheri_tag_ctrl.sv
// CHERI tag store: one validity tag per granule of a tagged region, with a
// bulk-clear sweep that runs after reset and on request.
module ibex_cheri_tag_ctrl #(
    parameter int unsigned TagMemSize  = 4096,
    parameter logic [31:0] BaseAddr    = 32'h0010_0000,
    parameter int unsigned GranuleLog2 = 3,
    parameter int unsigned ClearWidth  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    ibex_cheri_tag_ctrl_if.slave       bus,
    input  logic                       clear_start_i,
    output logic                       clear_busy_o,
    output logic                       clear_done_o
);

    localparam int unsigned NumWords = TagMemSize / ClearWidth;
    localparam int unsigned CtrW     = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned IdxW     = (TagMemSize > 1) ? $clog2(TagMemSize) : 1;
    localparam logic [CtrW-1:0] LastWord = CtrW'(NumWords - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CtrW-1:0]     ctr_q, ctr_d;
    logic                clear_done_d;
    logic                sweep_en;

    logic [TagMemSize-1:0] tags;

    logic [31:0]         off;
    logic [31:0]         idx_full;
    logic [IdxW-1:0]     idx;
    logic                in_range;
    logic                gnt_c;
    logic                accept;

    logic                rvalid_q;
    logic                rdata_tag_q;
    logic                err_q;

    // Address decode: unsigned offset wraps below BaseAddr, so both bounds are checked.
    assign off      = bus.addr - BaseAddr;
    assign idx_full = off >> GranuleLog2;
    assign in_range = (bus.addr >= BaseAddr) && (idx_full < 32'(TagMemSize));
    assign idx      = idx_full[IdxW-1:0];

    assign gnt_c  = (state_q == ST_IDLE);
    assign accept = bus.req && gnt_c;

    // Next-state and sweep control.
    always_comb begin
        state_d      = state_q;
        ctr_d        = ctr_q;
        sweep_en     = 1'b0;
        clear_done_d = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                sweep_en = 1'b1;
                if (ctr_q == LastWord) begin
                    state_d = ST_IDLE;
                    ctr_d   = '0;
                end else begin
                    ctr_d   = ctr_q + CtrW'(1);
                end
            end
            ST_IDLE: begin
                if (clear_start_i) begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ctr_d   = '0;
            end
        endcase
        // Registered done flag is set ahead so it is high during the final sweep cycle.
        clear_done_d = (state_d == ST_CLEAR) && (ctr_d == LastWord);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_CLEAR;
            ctr_q        <= '0;
            clear_done_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            clear_done_o <= clear_done_d;
        end
    end

    // Tag array has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk_i) begin
        if (sweep_en) begin
            tags[32'(ctr_q) * ClearWidth +: ClearWidth] <= '0;
        end else if (accept && in_range && bus.we) begin
            tags[idx] <= bus.cap & bus.wdata_tag;
        end
    end

    // One-cycle response path.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q    <= 1'b0;
            rdata_tag_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rvalid_q    <= accept;
            rdata_tag_q <= accept && in_range && !bus.we && tags[idx];
            err_q       <= accept && !in_range;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata_tag = rdata_tag_q;
    assign bus.err       = err_q;
    assign clear_busy_o  = (state_q == ST_CLEAR);

endmodule
